sel_f2a: RTL and testbench

Host-to-FPGA packet demultiplexer: the write-direction counterpart of the FPGA-to-host selector. It accepts 32-bit words from the FTDI receive path and parses a header word at each packet start. It then routes the payload either to the ECPU command FIFO, or unpacked to 24-bit IQ pairs into the TX sample FIFO, and discards packets with unknown destinations.

---
 rtl/sel_f2a_pkg.sv | 32 +++
 rtl/sel_f2a_if.sv | 36 +++
 rtl/sel_f2a_hdr.sv | 24 ++
 rtl/sel_f2a.sv | 138 +++++++++++++
 tb/tb_sel_f2a.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/sel_f2a_pkg.sv
// Shared constants for the host-to-FPGA packet demultiplexer: header field
// positions, destination codes, FSM state encoding and IQ packing widths.
package sel_f2a_pkg;

    localparam int unsigned FT_DATA_WIDTH    = 32;
    localparam int unsigned IQ_PAIR_WIDTH    = 24;
    localparam int unsigned IQ_HALF_WIDTH    = IQ_PAIR_WIDTH / 2;
    localparam int unsigned QSTART_BIT_INDEX = 16;

    // Header layout
    localparam int unsigned DEST_MSB = 31;
    localparam int unsigned DEST_LSB = 28;
    localparam int unsigned N_MSB    = 27;
    localparam int unsigned N_LSB    = 20;

    localparam logic [3:0] DEST_CPU = 4'd0;
    localparam logic [3:0] DEST_IQ  = 4'd1;

    // One-hot FSM state bit positions
    localparam int unsigned ST_IDLE_IDX = 0;
    localparam int unsigned ST_CPU_IDX  = 1;
    localparam int unsigned ST_IQ_IDX   = 2;
    localparam int unsigned ST_DROP_IDX = 3;

    typedef enum logic [3:0] {
        StIdle   = 4'b0001,
        StCpuPay = 4'b0010,
        StIqPay  = 4'b0100,
        StDrop   = 4'b1000
    } state_e;

endpackage

// File: rtl/sel_f2a_if.sv
// Bus bundle of sel_f2a: FTDI receive side plus ECPU and TX FIFO write sides.
// SEL_F2A_DROPCNT_EN adds the drop_cnt_o counter signal.
interface sel_f2a_if;
    import sel_f2a_pkg::*;

    logic [FT_DATA_WIDTH-1:0] data_i;
    logic                     we_i;
    logic                     ready_o;
    logic [FT_DATA_WIDTH-1:0] cpu_data_o;
    logic                     cpu_we_o;
    logic                     cpu_full_i;
    logic [3:0]               cpu_blkcnt_o;
    logic [IQ_PAIR_WIDTH-1:0] iq_data_o;
    logic                     iq_we_o;
    logic                     iq_full_i;
`ifdef SEL_F2A_DROPCNT_EN
    logic [15:0]              drop_cnt_o;
`endif

    modport slave (
        input  data_i, we_i, cpu_full_i, iq_full_i,
        output ready_o, cpu_data_o, cpu_we_o, cpu_blkcnt_o, iq_data_o, iq_we_o
`ifdef SEL_F2A_DROPCNT_EN
        , drop_cnt_o
`endif
    );

    modport master (
        output data_i, we_i, cpu_full_i, iq_full_i,
        input  ready_o, cpu_data_o, cpu_we_o, cpu_blkcnt_o, iq_data_o, iq_we_o
`ifdef SEL_F2A_DROPCNT_EN
        , drop_cnt_o
`endif
    );

endinterface

// File: rtl/sel_f2a_hdr.sv
// Combinational header decoder: destination class and payload word count.
module sel_f2a_hdr
    import sel_f2a_pkg::*;
(
    input  logic [FT_DATA_WIDTH-1:0] word,
    output logic                     dest_cpu,
    output logic                     dest_iq,
    output logic                     dest_bad,
    output logic [7:0]               n
);

    logic [3:0] dest;
    logic       unused_opaque;

    assign dest     = word[DEST_MSB:DEST_LSB];
    assign n        = word[N_MSB:N_LSB];
    assign dest_cpu = (dest == DEST_CPU);
    assign dest_iq  = (dest == DEST_IQ);
    assign dest_bad = ~dest_cpu & ~dest_iq;

    // Low header bits carry no routing information
    assign unused_opaque = ^word[N_LSB-1:0];

endmodule

// File: rtl/sel_f2a.sv
// Host-to-FPGA packet demultiplexer. Parses a header per packet and routes the
// payload to the ECPU FIFO, to the TX FIFO as packed IQ pairs, or drops it.
// Optional build macro: SEL_F2A_DROPCNT_EN (invalid-destination header counter).
module sel_f2a
    import sel_f2a_pkg::*;
(
    input  logic     clk_i,
    input  logic     reset_n,
    sel_f2a_if.slave bus
);

    state_e                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     cpu_we_q, cpu_we_d;
    logic [FT_DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
    logic                     iq_we_q, iq_we_d;
    logic [IQ_PAIR_WIDTH-1:0] iq_data_q, iq_data_d;
    logic [3:0]               blkcnt_q, blkcnt_d;
    logic [FT_DATA_WIDTH-1:0] data;
    logic                     ready;
    logic                     accept;
    logic                     hdr_cpu, hdr_iq, hdr_bad;
    logic [7:0]               hdr_n;

    assign data   = bus.data_i;
    assign accept = bus.we_i & ready;

    sel_f2a_hdr u_hdr (
        .word     (data),
        .dest_cpu (hdr_cpu),
        .dest_iq  (hdr_iq),
        .dest_bad (hdr_bad),
        .n        (hdr_n)
    );

    // Intake readiness depends only on state and the downstream almost-full flags
    always_comb begin
        ready = 1'b1;
        unique case (state_q)
            StCpuPay: ready = ~bus.cpu_full_i;
            StIqPay:  ready = ~bus.iq_full_i;
            default:  ready = 1'b1;
        endcase
    end

    // Next-state, payload counter and registered write outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpu_we_d   = 1'b0;
        cpu_data_d = cpu_data_q;
        iq_we_d    = 1'b0;
        iq_data_d  = iq_data_q;
        blkcnt_d   = blkcnt_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    cnt_d = hdr_n;
                    if (hdr_cpu) begin
                        cpu_we_d   = 1'b1;
                        cpu_data_d = data;
                        if (hdr_n == 8'd0) blkcnt_d = blkcnt_q + 4'd1;
                        else               state_d  = StCpuPay;
                    end else if (hdr_iq) begin
                        if (hdr_n != 8'd0) state_d = StIqPay;
                    end else begin
                        if (hdr_n != 8'd0) state_d = StDrop;
                    end
                end
                StCpuPay: begin
                    cpu_we_d   = 1'b1;
                    cpu_data_d = data;
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        blkcnt_d = blkcnt_q + 4'd1;
                        state_d  = StIdle;
                    end
                end
                StIqPay: begin
                    iq_we_d   = 1'b1;
                    iq_data_d = {data[QSTART_BIT_INDEX+IQ_HALF_WIDTH-1:QSTART_BIT_INDEX],
                                 data[IQ_HALF_WIDTH-1:0]};
                    cnt_d     = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = StIdle;
                end
                StDrop: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers; reset also kills a strobe pending from the prior edge
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            cpu_we_q   <= 1'b0;
            cpu_data_q <= '0;
            iq_we_q    <= 1'b0;
            iq_data_q  <= '0;
            blkcnt_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_we_q   <= cpu_we_d;
            cpu_data_q <= cpu_data_d;
            iq_we_q    <= iq_we_d;
            iq_data_q  <= iq_data_d;
            blkcnt_q   <= blkcnt_d;
        end
    end

    assign bus.ready_o      = ready;
    assign bus.cpu_we_o     = cpu_we_q;
    assign bus.cpu_data_o   = cpu_data_q;
    assign bus.iq_we_o      = iq_we_q;
    assign bus.iq_data_o    = iq_data_q;
    assign bus.cpu_blkcnt_o = blkcnt_q;

`ifdef SEL_F2A_DROPCNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of headers with an invalid destination, N=0 included
    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            drop_cnt_q <= 16'd0;
        end else if (accept && (state_q == StIdle) && hdr_bad && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sel_f2a.sv
// Directed bench for sel_f2a: a per-cycle vector table for the main packet
// flows plus hand-written sequences for counter wrap and mid-packet reset.
module tb_sel_f2a;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    sel_f2a_if bus ();

    sel_f2a dut (
        .clk_i   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        we;
        logic        cfull;
        logic        ifull;
        logic        rdy;
        logic        cwe;
        logic [31:0] cdata;
        logic        iwe;
        logic [23:0] idata;
        logic [3:0]  blk;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, return at the sample point
    task automatic cyc(input logic [31:0] d, input logic we, input logic cf, input logic iqf);
        @(posedge clk);
        #1;
        bus.data_i     = d;
        bus.we_i       = we;
        bus.cpu_full_i = cf;
        bus.iq_full_i  = iqf;
        #3;
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic we, input logic cf,
                                input logic iqf, input logic rdy, input logic cwe,
                                input logic [31:0] cd, input logic iwe, input logic [23:0] id,
                                input logic [3:0] blk);
        vec_t v;
        v.data = d; v.we = we; v.cfull = cf; v.ifull = iqf; v.rdy = rdy;
        v.cwe = cwe; v.cdata = cd; v.iwe = iwe; v.idata = id; v.blk = blk;
        return v;
    endfunction

    int strobes;

    initial begin
        bus.data_i = '0;
        bus.we_i = 1'b0;
        bus.cpu_full_i = 1'b0;
        bus.iq_full_i = 1'b0;

        // Expected outputs are those visible during the cycle the inputs are driven
        // CPU N=3: header, A, B, C
        vecs[0]  = mk(32'h0030_0000, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[1]  = mk(32'h0000_000A, 1, 0, 0, 1, 1, 32'h0030_0000, 0, 0, 0);
        vecs[2]  = mk(32'h0000_000B, 1, 0, 0, 1, 1, 32'h0000_000A, 0, 0, 0);
        vecs[3]  = mk(32'h0000_000C, 1, 0, 0, 1, 1, 32'h0000_000B, 0, 0, 0);
        vecs[4]  = mk(32'h0,         0, 0, 0, 1, 1, 32'h0000_000C, 0, 0, 1);
        vecs[5]  = mk(32'h0,         0, 0, 0, 1, 0, 0, 0, 0, 1);
        // IQ N=2, header not forwarded
        vecs[6]  = mk(32'h1020_0000, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[7]  = mk(32'h0ABC_0123, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[8]  = mk(32'h0FFF_0800, 1, 0, 0, 1, 0, 0, 1, 24'hABC123, 1);
        vecs[9]  = mk(32'h0,         0, 0, 0, 1, 0, 0, 1, 24'hFFF800, 1);
        vecs[10] = mk(32'h0,         0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Bad DEST N=1 dropped, then CPU N=0
        vecs[11] = mk(32'h7010_0000, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[12] = mk(32'hDEAD_BEEF, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[13] = mk(32'h0000_0000, 1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[14] = mk(32'h0,         0, 0, 0, 1, 1, 32'h0000_0000, 0, 0, 2);
        vecs[15] = mk(32'h0,         0, 0, 0, 1, 0, 0, 0, 0, 2);
        // CPU N=4 with cpu_full high for five cycles
        vecs[16] = mk(32'h0040_0000, 1, 0, 0, 1, 0, 0, 0, 0, 2);
        vecs[17] = mk(32'h0000_0011, 1, 0, 0, 1, 1, 32'h0040_0000, 0, 0, 2);
        vecs[18] = mk(32'h0000_0022, 1, 1, 0, 0, 1, 32'h0000_0011, 0, 0, 2);
        vecs[19] = mk(32'h0000_0022, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        vecs[20] = mk(32'h0000_0022, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        vecs[21] = mk(32'h0000_0022, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        vecs[22] = mk(32'h0000_0022, 1, 1, 0, 0, 0, 0, 0, 0, 2);
        vecs[23] = mk(32'h0000_0022, 1, 0, 0, 1, 0, 0, 0, 0, 2);
        vecs[24] = mk(32'h0000_0033, 1, 0, 0, 1, 1, 32'h0000_0022, 0, 0, 2);
        vecs[25] = mk(32'h0000_0044, 1, 0, 0, 1, 1, 32'h0000_0033, 0, 0, 2);
        vecs[26] = mk(32'h0,         0, 0, 0, 1, 1, 32'h0000_0044, 0, 0, 3);
        // Idle ignores both full flags
        vecs[27] = mk(32'h0,         0, 1, 1, 1, 0, 0, 0, 0, 3);

        // Reset and reset-state checks
        cyc(32'h0, 0, 0, 0);
        cyc(32'h0, 0, 0, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #3;
        check("rst_ready",  {31'b0, bus.ready_o},    32'd1);
        check("rst_cpu_we", {31'b0, bus.cpu_we_o},   32'd0);
        check("rst_iq_we",  {31'b0, bus.iq_we_o},    32'd0);
        check("rst_cdata",  bus.cpu_data_o,          32'd0);
        check("rst_idata",  {8'b0, bus.iq_data_o},   32'd0);
        check("rst_blk",    {28'b0, bus.cpu_blkcnt_o}, 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].data, vecs[i].we, vecs[i].cfull, vecs[i].ifull);
            check($sformatf("v%0d_ready", i),  {31'b0, bus.ready_o},  {31'b0, vecs[i].rdy});
            check($sformatf("v%0d_cpu_we", i), {31'b0, bus.cpu_we_o}, {31'b0, vecs[i].cwe});
            check($sformatf("v%0d_iq_we", i),  {31'b0, bus.iq_we_o},  {31'b0, vecs[i].iwe});
            check($sformatf("v%0d_blk", i), {28'b0, bus.cpu_blkcnt_o}, {28'b0, vecs[i].blk});
            if (vecs[i].cwe)
                check($sformatf("v%0d_cdata", i), bus.cpu_data_o, vecs[i].cdata);
            if (vecs[i].iwe)
                check($sformatf("v%0d_idata", i), {8'b0, bus.iq_data_o}, {8'b0, vecs[i].idata});
        end
`ifdef SEL_F2A_DROPCNT_EN
        check("drop_cnt", {16'b0, bus.drop_cnt_o}, 32'd1);
`endif

        // Seventeen CPU N=0 packets from reset wrap the block count to 1
        @(posedge clk);
        #1 reset_n = 1'b0;
        bus.we_i = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 17; i++) begin
            cyc(32'h0000_0000, 1, 0, 0);
            if (bus.cpu_we_o) strobes++;
        end
        cyc(32'h0, 0, 0, 0);
        if (bus.cpu_we_o) strobes++;
        check("wrap_strobes", strobes, 32'd17);
        check("wrap_blk", {28'b0, bus.cpu_blkcnt_o}, 32'd1);

        // Reset after 2 of 5 IQ payload words
        cyc(32'h1050_0000, 1, 0, 0);
        cyc(32'h0AAA_0555, 1, 0, 0);
        cyc(32'h0BBB_0666, 1, 0, 0);
        check("mid_iq1_we", {31'b0, bus.iq_we_o}, 32'd1);
        check("mid_iq1_data", {8'b0, bus.iq_data_o}, 32'h00AA_A555);
        @(posedge clk);
        #1 reset_n = 1'b0;
        bus.we_i = 1'b0;
        #3;
        check("mid_iq2_we", {31'b0, bus.iq_we_o}, 32'd1);
        check("mid_iq2_data", {8'b0, bus.iq_data_o}, 32'h00BB_B666);
        @(posedge clk);
        #1 reset_n = 1'b1;
        #3;
        check("mid_rst_iq_we", {31'b0, bus.iq_we_o}, 32'd0);
        check("mid_rst_blk", {28'b0, bus.cpu_blkcnt_o}, 32'd0);
        check("mid_rst_idata", {8'b0, bus.iq_data_o}, 32'd0);
        cyc(32'h0010_0000, 1, 0, 0);
        check("mid_hdr_ready", {31'b0, bus.ready_o}, 32'd1);
        check("mid_hdr_iq_we", {31'b0, bus.iq_we_o}, 32'd0);
        // cpu_full high: ready drops only if the word was taken as a CPU header
        cyc(32'h0, 0, 1, 0);
        check("mid_cpu_state", {31'b0, bus.ready_o}, 32'd0);
        check("mid_hdr_we", {31'b0, bus.cpu_we_o}, 32'd1);
        check("mid_hdr_data", bus.cpu_data_o, 32'h0010_0000);
        check("mid_hdr_no_iq", {31'b0, bus.iq_we_o}, 32'd0);
        cyc(32'h0000_0055, 1, 0, 0);
        check("mid_pay_ready", {31'b0, bus.ready_o}, 32'd1);
        cyc(32'h0, 0, 0, 0);
        check("mid_pay_we", {31'b0, bus.cpu_we_o}, 32'd1);
        check("mid_pay_data", bus.cpu_data_o, 32'h0000_0055);
        check("mid_pay_blk", {28'b0, bus.cpu_blkcnt_o}, 32'd1);
        check("mid_pay_no_iq", {31'b0, bus.iq_we_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
